au_operand_arbiter: RTL and testbench
=====================================

Name: au_operand_arbiter

Overview:
- Round-robin arbiter for the 32-bit 4:1 operand mux in the arithmetic unit.
- Accepts requests from four operand sources and grants exactly one at a time.
- Drives the mux select pair (s1, s0) and presents a valid/ready handshake towards the arithmetic unit.
- A grant is held for a burst of up to MAX_BURST accepted beats, so a requester can stream operands without re-arbitrating.

Parameters:
- MAX_BURST, 4, maximum accepted beats per grant; legal range 1..255.
- CNT_W, 8, width of the internal beat counter; must be large enough to hold MAX_BURST.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, synchronous, active-low.
- req  input  4  per-requester request; bit i belongs to mux input i; must be held high while the requester has data.
- out_ready  input  1  arithmetic unit can accept an operand this cycle.
- gnt  output  4  one-hot grant, registered; all zero when idle.
- s1  output  1  mux select MSB; equals grant index bit 1, registered.
- S0  output  1  mux select LSB; equals grant index bit 0, registered.
- out_valid  output  1  selected operand valid; combinational, equals busy AND req[idx].
- ack  output  4  one-hot beat-accepted strobe to the granted requester; combinational, equals gnt when out_valid AND out_ready, otherwise 0.
- busy  output  1  a grant is active, registered.

Behaviour:
- Reset (rst_n low at a clk edge) clears all state:
  - gnt = 0, s1 = 0, S0 = 0, busy = 0.
  - Beat count = 0, round-robin pointer = 0.
  - out_valid = 0 and ack = 0 follow from these.
  - A reset mid-burst aborts the burst; no ack is generated in the reset cycle.
- States: IDLE (busy = 0) and GRANT (busy = 1).
- IDLE:
  - If req != 0, choose the first set bit scanning pointer, pointer+1, ... modulo 4.
  - Next cycle: enter GRANT, gnt = onehot(idx), {s1,S0} = idx, beat count = 0.
  - If req == 0, stay in IDLE.
- GRANT:
  - A beat occurs when out_valid and out_ready are both 1; on a beat the beat count increments.
  - Release on a beat that makes count == MAX_BURST. Release takes effect next cycle.
  - Release when req[idx] == 0 in any GRANT cycle; no beat occurs in that cycle.
  - On release: go to IDLE, gnt = 0, busy = 0, pointer = idx+1 mod 4.
  - {s1,S0} keep their last value while idle; they are don't-care to the consumer.
  - When out_ready = 0 with req[idx] = 1, hold the grant indefinitely (no timeout).
- Arbitration occurs only in IDLE, so there is always at least one idle cycle between consecutive grants. Back-to-back bursts from different requesters therefore cost one bubble.
- Requests from non-granted requesters have no effect during GRANT. They are considered at the next IDLE cycle.
- The requester priority order rotates after every grant, whether the release came from burst completion or from req dropping. A requester that just released has lowest priority next round.
- Simultaneous req drop and MAX_BURST completion in the same cycle: treat as a req-drop release (no beat, since out_valid = 0). The outcome is the same: IDLE, pointer advances.
- MAX_BURST = 1: release after every beat, giving strict round-robin per operand.
- Grant, select and busy are registered. Only out_valid and ack are combinational from req and out_ready, giving zero-latency handshake.

Test Plan:
- Reset, single requester: rst_n low 2 cycles, then req = 0001 with out_ready = 1.
  - Cycle 1 after release: IDLE.
  - Cycle 2: gnt = 0001, {s1,S0} = 00, busy = 1.
  - 4 acks follow, then gnt = 0 for one cycle, then re-grant to 0.
- Round-robin fairness: req = 1111 held, out_ready = 1, MAX_BURST = 4.
  - Grant order 0,1,2,3,0, each burst exactly 4 acks.
  - {s1,S0} = 00,01,10,11,00.
- Backpressure: grant to requester 2, out_ready = 0 for 10 cycles.
  - gnt = 0100 held, out_valid = 1, ack = 0, beat count stays 0.
  - After out_ready rises, 4 acks follow.
- Early release: requester 1 granted, drops req after 2 beats while req[3] = 1.
  - Next cycle IDLE, following cycle gnt = 1000.
  - Pointer skips 2 because req[2] = 0.
- Mid-burst reset: rst_n low during beat 3 of a burst.
  - Next cycle gnt = 0, busy = 0, {s1,S0} = 00.
  - After reset, req = 1010 grants requester 1 first (pointer = 0).
- MAX_BURST = 1: req = 0101, out_ready = 1.
  - Grants alternate 0,2,0,2 with one ack each and one idle cycle between grants.

Source files
------------

// File: rtl/au_operand_arbiter.sv
// au_operand_arbiter: round-robin burst arbiter for the arithmetic unit's
// 32-bit 4:1 operand mux. One requester holds the grant for up to MAX_BURST
// accepted beats, or until it drops req. The grant, the mux select and busy
// are registered. out_valid and ack are combinational, so the handshake has
// zero latency.
module au_operand_arbiter #(
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       out_ready,
  output logic [3:0] gnt,
  output logic       s1,
  output logic       S0,
  output logic       out_valid,
  output logic [3:0] ack,
  output logic       busy
);

  localparam int NUM_REQ = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e           state_q;
  logic [3:0]       gnt_q;
  logic [1:0]       idx_q;    // granted index, also drives {s1,S0}
  logic [1:0]       ptr_q;    // highest-priority requester for the next arbitration
  logic [CNT_W-1:0] cnt_q;    // beats accepted in the current burst
  logic [CNT_W-1:0] cnt_d;

  logic [1:0]       pick_idx;
  logic             pick_vld;
  logic             beat;
  logic             last_beat;
  logic             req_held;

  // Scan ptr, ptr+1, ... (mod 4). Scanning from the farthest slot down lets
  // the nearest set bit overwrite the others.
  always_comb begin
    pick_idx = ptr_q;
    pick_vld = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[ptr_q + 2'(k)]) begin
        pick_idx = ptr_q + 2'(k);
        pick_vld = 1'b1;
      end
    end
  end

  // Handshake. It is gated by rst_n so that a reset cycle never produces a beat.
  assign req_held  = req[idx_q];
  assign out_valid = rst_n & (state_q == GRANT) & req_held;
  assign beat      = out_valid & out_ready;
  assign last_beat = (cnt_q == CNT_W'(MAX_BURST - 1));
  assign cnt_d     = cnt_q + CNT_W'(1);

  // Per-requester accept strobe
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_ack
    assign ack[i] = gnt_q[i] & beat;
  end

  // Arbitration FSM: IDLE picks a winner, GRANT streams beats until release
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            state_q <= GRANT;
            gnt_q   <= 4'b0001 << pick_idx;
            idx_q   <= pick_idx;
            cnt_q   <= '0;
          end
        end
        GRANT: begin
          // A req drop releases the grant with no beat, because out_valid is
          // low in that cycle. That also covers a drop that coincides with
          // the final beat of a burst.
          if (!req_held || (beat && last_beat)) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ptr_q   <= idx_q + 2'd1;
            cnt_q   <= '0;
          end else if (beat) begin
            cnt_q   <= cnt_d;
          end
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= '0;
        end
      endcase
    end
  end

  assign gnt  = gnt_q;
  assign s1   = idx_q[1];
  assign S0   = idx_q[0];
  assign busy = (state_q == GRANT);

endmodule

// File: tb/tb_au_operand_arbiter.sv
// Bench for au_operand_arbiter. A table of per-cycle {inputs, expected outputs}
// rows exercises the default MAX_BURST=4 instance. A hand-written sequence
// checks a second instance built with MAX_BURST=1.
module tb_au_operand_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req, req1;
  logic       out_ready, rdy1;
  logic [3:0] gnt, ack, gnt1, ack1;
  logic       s1, S0, out_valid, busy;
  logic       s1_1, S0_1, out_valid1, busy1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  au_operand_arbiter #(.MAX_BURST(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .out_ready(out_ready),
    .gnt(gnt), .s1(s1), .S0(S0), .out_valid(out_valid), .ack(ack), .busy(busy)
  );

  au_operand_arbiter #(.MAX_BURST(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req1), .out_ready(rdy1),
    .gnt(gnt1), .s1(s1_1), .S0(S0_1), .out_valid(out_valid1), .ack(ack1), .busy(busy1)
  );

  typedef struct packed {
    logic       rst_n;
    logic [3:0] req;
    logic       rdy;
    logic [3:0] gnt;
    logic       busy;
    logic [1:0] sel;
    logic       valid;
    logic [3:0] ack;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  logic [11:0] exp1_q[$];

  task automatic add(input logic r, input logic [3:0] rq, input logic rd,
                     input logic [3:0] g, input logic b, input logic [1:0] sl,
                     input logic v, input logic [3:0] a);
    vec_t t;
    t.rst_n = r; t.req = rq; t.rdy = rd; t.gnt = g; t.busy = b;
    t.sel = sl; t.valid = v; t.ack = a;
    tbl.push_back(t);
  endtask

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got gnt/busy/sel/valid/ack=%b expected %b", name, act, exp);
    end
  endtask

  initial begin
    vec_t   e;
    vec_t   d;
    logic [11:0] e1;
    logic [3:0]  g1_seq[8];
    logic        b1_seq[8];

    // ---- stimulus/expectation table ----
    // Scenario 1: single requester, full burst, re-grant, drop release
    add(1, 4'h1, 1, 4'h0, 0, 2'd0, 0, 4'h0);
    for (int k = 0; k < 4; k++) add(1, 4'h1, 1, 4'h1, 1, 2'd0, 1, 4'h1);
    add(1, 4'h1, 1, 4'h0, 0, 2'd0, 0, 4'h0);
    add(1, 4'h1, 1, 4'h1, 1, 2'd0, 1, 4'h1);
    add(1, 4'h0, 1, 4'h1, 1, 2'd0, 0, 4'h0);
    add(1, 4'h0, 1, 4'h0, 0, 2'd0, 0, 4'h0);
    add(0, 4'h0, 1, 4'h0, 0, 2'd0, 0, 4'h0);
    // Scenario 2: round-robin with all four requesting
    add(1, 4'hF, 1, 4'h0, 0, 2'd0, 0, 4'h0);
    for (int g = 0; g < 5; g++) begin
      for (int k = 0; k < 4; k++)
        add(1, 4'hF, 1, 4'(1 << (g % 4)), 1, 2'(g % 4), 1, 4'(1 << (g % 4)));
      add(1, 4'hF, 1, 4'h0, 0, 2'(g % 4), 0, 4'h0);
    end
    // Reset lands while requester 1 is granted. Nothing is valid in that cycle.
    add(0, 4'h0, 1, 4'h2, 1, 2'd1, 0, 4'h0);
    // Scenario 3: backpressure on requester 2
    add(1, 4'h4, 0, 4'h0, 0, 2'd0, 0, 4'h0);
    for (int k = 0; k < 10; k++) add(1, 4'h4, 0, 4'h4, 1, 2'd2, 1, 4'h0);
    for (int k = 0; k < 4; k++)  add(1, 4'h4, 1, 4'h4, 1, 2'd2, 1, 4'h4);
    add(1, 4'h0, 1, 4'h0, 0, 2'd2, 0, 4'h0);
    add(0, 4'h0, 1, 4'h0, 0, 2'd2, 0, 4'h0);
    // Scenario 4: early release by requester 1, pointer skips idle requester 2
    add(1, 4'hA, 1, 4'h0, 0, 2'd0, 0, 4'h0);
    add(1, 4'hA, 1, 4'h2, 1, 2'd1, 1, 4'h2);
    add(1, 4'hA, 1, 4'h2, 1, 2'd1, 1, 4'h2);
    add(1, 4'h8, 1, 4'h2, 1, 2'd1, 0, 4'h0);
    add(1, 4'h8, 1, 4'h0, 0, 2'd1, 0, 4'h0);
    add(1, 4'h8, 1, 4'h8, 1, 2'd3, 1, 4'h8);
    add(1, 4'h0, 1, 4'h8, 1, 2'd3, 0, 4'h0);
    add(1, 4'h0, 1, 4'h0, 0, 2'd3, 0, 4'h0);
    // Scenario 5: reset asserted during beat 3 of a burst
    add(1, 4'h1, 1, 4'h0, 0, 2'd3, 0, 4'h0);
    add(1, 4'h1, 1, 4'h1, 1, 2'd0, 1, 4'h1);
    add(1, 4'h1, 1, 4'h1, 1, 2'd0, 1, 4'h1);
    add(0, 4'h1, 1, 4'h1, 1, 2'd0, 0, 4'h0);
    add(1, 4'hA, 1, 4'h0, 0, 2'd0, 0, 4'h0);
    add(1, 4'hA, 1, 4'h2, 1, 2'd1, 1, 4'h2);
    add(1, 4'h0, 1, 4'h2, 1, 2'd1, 0, 4'h0);
    add(1, 4'h0, 1, 4'h0, 0, 2'd1, 0, 4'h0);

    // ---- reset ----
    rst_n = 1'b0; req = '0; out_ready = 1'b1; req1 = '0; rdy1 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {gnt, busy, s1, S0, out_valid, ack}, 12'b0);
    check("reset_state_mb1", {gnt1, busy1, s1_1, S0_1, out_valid1, ack1}, 12'b0);

    // ---- table-driven run: push expectation on drive, pop on sample ----
    for (int i = 0; i < tbl.size(); i++) begin
      d = tbl[i];
      rst_n = d.rst_n; req = d.req; out_ready = d.rdy;
      exp_q.push_back(d);
      #1;
      e = exp_q.pop_front();
      check($sformatf("row%0d", i), {gnt, busy, s1, S0, out_valid, ack},
            {e.gnt, e.busy, e.sel, e.valid, e.ack});
      @(posedge clk);
      #1;
    end

    // ---- MAX_BURST=1: strict alternation 0,2,0,2 with idle bubbles ----
    g1_seq = '{4'h0, 4'h1, 4'h0, 4'h4, 4'h0, 4'h1, 4'h0, 4'h4};
    b1_seq = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    req1 = 4'h5; rdy1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp1_q.push_back({g1_seq[i], b1_seq[i], b1_seq[i], 2'b00, g1_seq[i]});
      #1;
      e1 = exp1_q.pop_front();
      check($sformatf("mb1_cycle%0d", i),
            {gnt1, busy1, out_valid1, 2'b00, ack1}, e1);
      @(posedge clk);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
